// File: rtl/dict_ram_arbiter.sv
// Round-robin arbiter sharing the dictionary RAM between NUM_REQ cores, with a clear sweep
// of the multi-character codes. Optional search-then-insert locking is enabled by DICT_ARB_LOCK_EN.
module dict_ram_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64,
  parameter int BASE_CODE  = 256,
  parameter int LOCK_MAX   = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ-1:0]               req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             rsp_hit,
  input  logic                             clear_start,
  output logic                             busy,
  output logic                             clear_done,
  output logic                             ram_cs,
  output logic                             ram_we,
  output logic                             ram_inv,
  output logic [ADDR_WIDTH-1:0]            ram_addr,
  output logic [DATA_WIDTH-1:0]            ram_data_in,
  input  logic [DATA_WIDTH-1:0]            ram_data_out,
  input  logic                             ram_valid
);

  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [RW-1:0]         rr;
  logic [NUM_REQ-1:0]    eligible;
  logic                  gnt_any;
  logic [RW-1:0]         gnt_sel;
  int                    arb_idx;

  function automatic logic [RW-1:0] next_ptr(input logic [RW-1:0] p);
    return (int'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
  endfunction

`ifdef DICT_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);

  logic          locked;
  logic [RW-1:0] owner;
  logic [CW-1:0] lock_cnt;

  // An owner that drops its request loses the lock in that same cycle.
  always_comb begin
    eligible = req;
    if (locked && req[owner]) begin
      eligible        = '0;
      eligible[owner] = 1'b1;
    end
  end
`else
  localparam int unused_lock_max = LOCK_MAX;
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign eligible    = req;
`endif

  assign busy     = (state == ST_CLEAR);
  assign rsp_data = ram_data_out;
  assign rsp_hit  = ram_valid;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_sel = '0;
    arb_idx = 0;
    if (state == ST_IDLE && !clear_start) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        arb_idx = (int'(rr) + i) % NUM_REQ;
        if (!gnt_any && eligible[arb_idx]) begin
          gnt_any = 1'b1;
          gnt_sel = RW'(arb_idx);
        end
      end
      if (gnt_any) gnt[gnt_sel] = 1'b1;
    end
  end

  // The sweep is gated by rst so the RAM sees no invalidations while reset is held.
  always_comb begin
    ram_cs      = 1'b0;
    ram_we      = 1'b0;
    ram_inv     = 1'b0;
    ram_addr    = '0;
    ram_data_in = '0;
    if (state == ST_CLEAR && !rst) begin
      ram_cs   = 1'b1;
      ram_we   = 1'b1;
      ram_inv  = 1'b1;
      ram_addr = clr_addr;
    end else if (gnt_any) begin
      ram_cs      = 1'b1;
      ram_we      = req_we[gnt_sel];
      ram_addr    = req_addr[gnt_sel*ADDR_WIDTH +: ADDR_WIDTH];
      ram_data_in = req_wdata[gnt_sel*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_CLEAR;
      clr_addr   <= ADDR_WIDTH'(BASE_CODE);
      rr         <= '0;
      rsp_valid  <= '0;
      clear_done <= 1'b0;
`ifdef DICT_ARB_LOCK_EN
      locked     <= 1'b0;
      owner      <= '0;
      lock_cnt   <= '0;
`endif
    end else begin
      clear_done <= 1'b0;
      rsp_valid  <= gnt & ~req_we;
      case (state)
        ST_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == '1) begin
            state      <= ST_IDLE;
            clear_done <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (clear_start) begin
            state    <= ST_CLEAR;
            clr_addr <= ADDR_WIDTH'(BASE_CODE);
`ifdef DICT_ARB_LOCK_EN
            locked   <= 1'b0;
`endif
          end else begin
            if (gnt_any) rr <= next_ptr(gnt_sel);
`ifdef DICT_ARB_LOCK_EN
            if (locked && !req[owner]) locked <= 1'b0;
            if (gnt_any) begin
              if (locked && gnt_sel == owner) begin
                if (!req_lock[gnt_sel] || lock_cnt == CW'(LOCK_MAX - 1)) locked <= 1'b0;
                else lock_cnt <= lock_cnt + 1'b1;
              end else if (req_lock[gnt_sel]) begin
                locked   <= (LOCK_MAX > 1);
                owner    <= gnt_sel;
                lock_cnt <= CW'(1);
              end
            end
`endif
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_dict_ram_arbiter.sv
// Self-checking bench for dict_ram_arbiter: behavioural RAM, read scoreboard, directed scenarios.
// Lock scenario checks depend on DICT_ARB_LOCK_EN matching the RTL build.
module tb_dict_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, req_we, req_lock;
  logic [11:0] tb_addr  [2];
  logic [63:0] tb_wdata [2];
  logic [23:0] req_addr;
  logic [127:0] req_wdata;
  logic [1:0]  gnt, rsp_valid;
  logic [63:0] rsp_data;
  logic        rsp_hit, clear_start, busy, clear_done;
  logic        ram_cs, ram_we, ram_inv;
  logic [11:0] ram_addr;
  logic [63:0] ram_data_in, ram_data_out;
  logic        ram_valid;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  oh;
    logic [63:0] data;
    logic        hit;
  } exp_t;
  exp_t sb[$];

  logic [63:0] mem_d [4096];
  logic        mem_v [4096];
  logic [63:0] ref_d [4096];
  logic        ref_v [4096];

  assign req_addr  = {tb_addr[1], tb_addr[0]};
  assign req_wdata = {tb_wdata[1], tb_wdata[0]};

  always #5 clk = ~clk;

  dict_ram_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_hit(rsp_hit), .clear_start(clear_start), .busy(busy),
    .clear_done(clear_done), .ram_cs(ram_cs), .ram_we(ram_we), .ram_inv(ram_inv),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
    .ram_valid(ram_valid)
  );

  function automatic logic [63:0] init_word(input int a);
    return 64'hD1C7_0000_0000_0000 | (64'(a) * 64'h0000_0001_0000_0001);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural single-port RAM with a valid bit per entry.
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        if (ram_inv) mem_v[ram_addr] <= 1'b0;
        else begin
          mem_d[ram_addr] <= ram_data_in;
          mem_v[ram_addr] <= 1'b1;
        end
      end else begin
        ram_data_out <= mem_d[ram_addr];
        ram_valid    <= mem_v[ram_addr];
      end
    end
  end

  // Scoreboard: a read granted at one falling edge must respond at the next one.
  always @(negedge clk) begin
    if (rst) sb.delete();
    else begin
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_valid", 64'(rsp_valid), 64'(e.oh));
        check("rsp_hit", 64'(rsp_hit), 64'(e.hit));
        check("rsp_data", rsp_data, e.data);
      end else if (rsp_valid != 2'b00) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end
      for (int i = 0; i < 2; i++) begin
        if (gnt[i]) begin
          if (req_we[i]) begin
            ref_d[tb_addr[i]] = tb_wdata[i];
            ref_v[tb_addr[i]] = 1'b1;
          end else begin
            sb.push_back('{oh: 2'(1 << i), data: ref_d[tb_addr[i]], hit: ref_v[tb_addr[i]]});
          end
        end
      end
    end
  end

  // Follows a sweep from its first invalidation to clear_done.
  task automatic run_clear(input string tag);
    int   n    = 0;
    int   errs = 0;
    logic done = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (clear_done) begin
        done = 1'b1;
        break;
      end
      if (!(busy && ram_cs && ram_we && ram_inv && gnt == 2'b00 && ram_addr == 12'(256 + n)))
        errs++;
      n++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_cycles"}, 64'(n), 64'd3840);
    check({tag, "_sweep_errs"}, 64'(errs), 64'd0);
    check({tag, "_busy_low"}, 64'(busy), 64'd0);
    for (int a = 256; a < 4096; a++) ref_v[a] = 1'b0;
  endtask

  task automatic access(input int core, input logic we, input logic [11:0] addr,
                        input logic [63:0] data);
    logic seen = 1'b0;
    @(posedge clk); #1;
    req_we[core]   = we;
    tb_addr[core]  = addr;
    tb_wdata[core] = data;
    req[core]      = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (gnt[core]) begin
        seen = 1'b1;
        break;
      end
    end
    check("access_gnt", 64'(seen), 64'd1);
    @(posedge clk); #1;
    req[core]    = 1'b0;
    req_we[core] = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_g;
    int         n;
    logic       found;

    for (int a = 0; a < 4096; a++) begin
      mem_d[a] = init_word(a);
      mem_v[a] = 1'b1;
      ref_d[a] = init_word(a);
      ref_v[a] = 1'b1;
    end
    rst = 1'b1; req = '0; req_we = '0; req_lock = '0; clear_start = 1'b0;
    tb_addr[0] = '0; tb_addr[1] = '0; tb_wdata[0] = '0; tb_wdata[1] = '0;
    ram_data_out = '0; ram_valid = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_clear_done", 64'(clear_done), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_ram_ctl", 64'({ram_cs, ram_we, ram_inv}), 64'd0);

    @(posedge clk); #1 rst = 1'b0;
    run_clear("clr0");

    // Both cores read continuously: strict alternation starting with core 0.
    @(posedge clk); #1;
    req = 2'b11; tb_addr[0] = 12'h100; tb_addr[1] = 12'h200;
    exp_g = 2'b01;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rr_alt", 64'(gnt), 64'(exp_g));
      exp_g = ~exp_g;
    end
    @(posedge clk); #1 req = 2'b00;

    // Write by core 1, then read back by core 0.
    access(1, 1'b1, 12'h300, 64'h4142);
    access(0, 1'b0, 12'h300, 64'h0);

    // Lock scenario: core 1 comes first (pointer sits at 1 after core 0's read).
    @(posedge clk); #1;
    req = 2'b11; req_lock = 2'b01; tb_addr[0] = 12'h100; tb_addr[1] = 12'h200;
    @(negedge clk);
    check("lock_first", 64'(gnt), 64'd2);
`ifdef DICT_ARB_LOCK_EN
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt == 2'b01) n++;
      else break;
    end
    check("lock_count", 64'(n), 64'd16);
    check("lock_release", 64'(gnt), 64'd2);
`else
    exp_g = 2'b01;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("nolock_alt", 64'(gnt), 64'(exp_g));
      exp_g = ~exp_g;
    end
`endif
    @(posedge clk); #1 req = 2'b00; req_lock = 2'b00;

    // clear_start wins over pending requests; grants resume on clear_done.
    @(posedge clk); #1;
    req = 2'b11; clear_start = 1'b1;
    @(negedge clk);
    check("cs_no_gnt", 64'(gnt), 64'd0);
    check("cs_no_ram", 64'(ram_cs), 64'd0);
    @(posedge clk); #1 clear_start = 1'b0;
    run_clear("clr1");
    check("cs_gnt_resume", 64'(gnt != 2'b00), 64'd1);
    @(posedge clk); #1 req = 2'b00;

    // Reset in the middle of a sweep restarts it from the base code.
    @(posedge clk); #1 clear_start = 1'b1;
    @(posedge clk); #1 clear_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (ram_inv && ram_addr == 12'h800) begin
        found = 1'b1;
        break;
      end
    end
    check("mid_reach_800", 64'(found), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_ctl", 64'({ram_cs, clear_done, busy}), 64'd1);
    check("mid_rst_rsp", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    run_clear("clr2");

    // Reset drops a pending read response.
    @(posedge clk); #1;
    req = 2'b01; tb_addr[0] = 12'h010;
    @(negedge clk);
    check("pend_gnt", 64'(gnt), 64'd1);
    @(posedge clk); #1 req = 2'b00;
    check("pend_rsp_set", 64'(rsp_valid), 64'd1);
    rst = 1'b1;
    #1 check("pend_rsp_cleared", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    run_clear("clr3");

    repeat (2) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
